// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// default geometry, FSM state encoding and a saturating counter helper.
package cache_pkg;

    localparam int CACHE_ADDR_WIDTH   = 32;
    localparam int CACHE_INDEX_WIDTH  = 10;
    localparam int CACHE_OFFSET_WIDTH = 4;
    localparam int CACHE_WORD_WIDTH   = 32;
    localparam int CACHE_BLOCK_WIDTH  = 128;
    localparam int CACHE_TAG_WIDTH    = CACHE_ADDR_WIDTH - CACHE_INDEX_WIDTH - CACHE_OFFSET_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_ALLOCATE,
        ST_WRITE_MEM
    } cache_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/tag_array.sv
// Tag store with one valid bit per line: combinational read, synchronous write,
// and a synchronous reset that invalidates every line at once.
module tag_array #(
    parameter int INDEX_WIDTH = 10,
    parameter int TAG_WIDTH   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic                   rd_valid,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    // Tag contents are don't-care until the line's valid bit is set, so no reset.
    logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
    logic [DEPTH-1:0]     valid_vec;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_line
            logic valid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                end else if (wr_en && (wr_index == INDEX_WIDTH'(gi))) begin
                    valid_reg <= 1'b1;
                end
            end

            assign valid_vec[gi] = valid_reg;
        end
    endgenerate

    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_vec[rd_index];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller driving an
// external data array and a single-request memory port.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH   = CACHE_ADDR_WIDTH,
    parameter int INDEX_WIDTH  = CACHE_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = CACHE_OFFSET_WIDTH,
    parameter int WORD_WIDTH   = CACHE_WORD_WIDTH,
    parameter int BLOCK_WIDTH  = CACHE_BLOCK_WIDTH,
    parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [WORD_WIDTH-1:0]   cpu_wdata,
    output logic [WORD_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_done,
    output logic [INDEX_WIDTH-1:0]  da_index,
    output logic [OFFSET_WIDTH-1:0] da_offset,
    output logic [WORD_WIDTH-1:0]   da_wdata,
    output logic                    da_refill,
    output logic                    da_update,
    input  logic [WORD_WIDTH-1:0]   da_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WORD_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
);

    generate
        if (BLOCK_WIDTH != (8 << OFFSET_WIDTH)) begin : g_geometry_check
            $error("cache_ctrl: BLOCK_WIDTH does not match OFFSET_WIDTH");
        end
    endgenerate

    cache_state_t            state_reg, state_next;
    logic                    we_reg, we_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [WORD_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                    refilled_reg, refilled_next;
    logic [15:0]             hit_count_reg, hit_count_next;
    logic [15:0]             miss_count_reg, miss_count_next;

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [OFFSET_WIDTH-1:0] req_offset;
    logic [TAG_WIDTH-1:0]    stored_tag;
    logic                    stored_valid;
    logic                    hit;
    logic                    tag_wr;

    assign req_tag    = addr_reg[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign req_index  = addr_reg[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_offset = addr_reg[OFFSET_WIDTH-1:0];

    tag_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index),
        .rd_tag   (stored_tag),
        .rd_valid (stored_valid),
        .wr_en    (tag_wr),
        .wr_index (req_index),
        .wr_tag   (req_tag)
    );

    assign hit = stored_valid && (stored_tag == req_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            refilled_reg   <= 1'b0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            refilled_reg   <= refilled_next;
            hit_count_reg  <= hit_count_next;
            miss_count_reg <= miss_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        refilled_next   = refilled_reg;
        hit_count_next  = hit_count_reg;
        miss_count_next = miss_count_reg;
        cpu_done        = 1'b0;
        da_refill       = 1'b0;
        da_update       = 1'b0;
        tag_wr          = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_req) begin
                    we_next       = cpu_we;
                    addr_next     = cpu_addr;
                    wdata_next    = cpu_wdata;
                    refilled_next = 1'b0;
                    state_next    = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!we_reg) begin
                    if (hit) begin
                        cpu_done   = 1'b1;
                        // A hit right after a refill completes the original miss.
                        if (!refilled_reg) begin
                            hit_count_next = sat_inc(hit_count_reg);
                        end
                        state_next = ST_IDLE;
                    end else begin
                        miss_count_next = sat_inc(miss_count_reg);
                        state_next      = ST_ALLOCATE;
                    end
                end else begin
                    if (hit) begin
                        da_update      = 1'b1;
                        hit_count_next = sat_inc(hit_count_reg);
                    end else begin
                        miss_count_next = sat_inc(miss_count_reg);
                    end
                    state_next = ST_WRITE_MEM;
                end
            end
            ST_ALLOCATE: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    da_refill     = 1'b1;
                    tag_wr        = 1'b1;
                    refilled_next = 1'b1;
                    state_next    = ST_COMPARE;
                end
            end
            ST_WRITE_MEM: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    cpu_done   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // An ack that lands on the reset edge must not touch the arrays.
        if (rst) begin
            cpu_done  = 1'b0;
            da_refill = 1'b0;
            da_update = 1'b0;
            tag_wr    = 1'b0;
        end
    end

    assign cpu_rdata  = (cpu_done && !we_reg) ? da_rdata : '0;
    assign da_index   = (state_reg == ST_IDLE) ? cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH] : req_index;
    assign da_offset  = (state_reg == ST_IDLE) ? cpu_addr[OFFSET_WIDTH-1:0] : req_offset;
    assign da_wdata   = wdata_reg;
    assign mem_addr   = (state_reg == ST_ALLOCATE)
                        ? {addr_reg[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}}
                        : addr_reg;
    assign mem_wdata  = wdata_reg;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural data array and a
// latency-programmable memory responder.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic [9:0]  da_index;
    logic [3:0]  da_offset;
    logic [31:0] da_wdata;
    logic        da_refill;
    logic        da_update;
    logic [31:0] da_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic [127:0] mem_rdata;
    logic [127:0] line_mem [1024];

    int total = 0;
    int bad   = 0;

    int refill_cnt = 0;
    int update_cnt = 0;
    int both_cnt   = 0;

    int          mem_rd_cnt = 0;
    int          mem_wr_cnt = 0;
    logic [31:0] last_mem_addr;
    logic [31:0] last_mem_wdata;
    int          stab_err = 0;

    localparam logic [127:0] LINE = {32'h8888_7777, 32'h6666_5555, 32'h4444_3333, 32'h2222_1111};

    cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .da_index   (da_index),
        .da_offset  (da_offset),
        .da_wdata   (da_wdata),
        .da_refill  (da_refill),
        .da_update  (da_update),
        .da_rdata   (da_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Data array model: whole-line refill from memory, single-word update.
    assign da_rdata = line_mem[da_index][{da_offset[3:2], 5'b0} +: 32];

    always @(posedge clk) begin
        if (da_refill) line_mem[da_index] <= mem_rdata;
        if (da_update) line_mem[da_index][{da_offset[3:2], 5'b0} +: 32] <= da_wdata;
    end

    always @(posedge clk) begin
        if (da_refill) refill_cnt++;
        if (da_update) update_cnt++;
        if (da_refill && da_update) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one CPU request and act as memory until cpu_done or a cycle budget runs out.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, output logic got, output logic [31:0] rdata,
                          output int cycles);
        int          mem_wait;
        logic        prev_req;
        logic [31:0] cap_addr;
        logic [31:0] cap_wdata;
        logic        cap_we;
        mem_wait  = 0;
        prev_req  = 1'b0;
        cap_addr  = '0;
        cap_wdata = '0;
        cap_we    = 1'b0;
        got       = 1'b0;
        rdata     = '0;
        cycles    = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        while (!got && cycles < 50) begin
            cyc();
            cycles++;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!prev_req) begin
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    cap_we    = mem_we;
                    prev_req  = 1'b1;
                end else if (cap_addr !== mem_addr || cap_wdata !== mem_wdata || cap_we !== mem_we) begin
                    stab_err++;
                end
                if (mem_wait == lat) begin
                    mem_ack        = 1'b1;
                    last_mem_addr  = mem_addr;
                    last_mem_wdata = mem_wdata;
                    if (mem_we) mem_wr_cnt++;
                    else        mem_rd_cnt++;
                    mem_wait = 0;
                    prev_req = 1'b0;
                end else begin
                    mem_wait++;
                end
            end
            #1;
            if (cpu_done) begin
                got   = 1'b1;
                rdata = cpu_rdata;
            end
        end
        cyc();
        mem_ack = 1'b0;
        cpu_req = 1'b0;
    endtask

    initial begin
        logic        got;
        logic [31:0] rdata;
        int          cycles;
        int          rd0, wr0, rf0, up0;

        for (int i = 0; i < 1024; i++) line_mem[i] = '0;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = LINE;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_miss_count", 32'(miss_count), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_cpu_done", 32'(cpu_done), 32'd0);

        // Cold read miss with three wait cycles on memory.
        rd0 = mem_rd_cnt; rf0 = refill_cnt;
        do_req(1'b0, 32'h0000_1230, 32'h0, 3, got, rdata, cycles);
        check("cold_done", 32'(got), 32'd1);
        check("cold_rdata", rdata, 32'h2222_1111);
        check("cold_cycles", 32'(cycles), 32'd6);
        check("cold_mem_reads", 32'(mem_rd_cnt - rd0), 32'd1);
        check("cold_mem_addr", last_mem_addr, 32'h0000_1230);
        check("cold_refills", 32'(refill_cnt - rf0), 32'd1);
        check("cold_miss_count", 32'(miss_count), 32'd1);
        check("cold_hit_count", 32'(hit_count), 32'd0);

        // Repeat read in the same line hits with single-cycle latency.
        rd0 = mem_rd_cnt;
        do_req(1'b0, 32'h0000_1234, 32'h0, 0, got, rdata, cycles);
        check("hit_rdata", rdata, 32'h4444_3333);
        check("hit_cycles", 32'(cycles), 32'd1);
        check("hit_no_mem", 32'(mem_rd_cnt - rd0), 32'd0);
        check("hit_hit_count", 32'(hit_count), 32'd1);
        check("hit_miss_count", 32'(miss_count), 32'd1);

        // Write hit: array update plus write-through.
        wr0 = mem_wr_cnt; up0 = update_cnt; rf0 = refill_cnt;
        do_req(1'b1, 32'h0000_1238, 32'hDEAD_BEEF, 2, got, rdata, cycles);
        check("wh_done", 32'(got), 32'd1);
        check("wh_cycles", 32'(cycles), 32'd4);
        check("wh_updates", 32'(update_cnt - up0), 32'd1);
        check("wh_refills", 32'(refill_cnt - rf0), 32'd0);
        check("wh_mem_writes", 32'(mem_wr_cnt - wr0), 32'd1);
        check("wh_mem_addr", last_mem_addr, 32'h0000_1238);
        check("wh_mem_wdata", last_mem_wdata, 32'hDEAD_BEEF);
        check("wh_hit_count", 32'(hit_count), 32'd2);

        do_req(1'b0, 32'h0000_1238, 32'h0, 0, got, rdata, cycles);
        check("rd_after_wr_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_after_wr_hits", 32'(hit_count), 32'd3);

        // Write miss to the same index with a different tag: memory only.
        wr0 = mem_wr_cnt; up0 = update_cnt;
        do_req(1'b1, 32'h0008_1230, 32'h1234_5678, 0, got, rdata, cycles);
        check("wm_cycles", 32'(cycles), 32'd2);
        check("wm_updates", 32'(update_cnt - up0), 32'd0);
        check("wm_mem_writes", 32'(mem_wr_cnt - wr0), 32'd1);
        check("wm_mem_addr", last_mem_addr, 32'h0008_1230);
        check("wm_mem_wdata", last_mem_wdata, 32'h1234_5678);
        check("wm_miss_count", 32'(miss_count), 32'd2);

        do_req(1'b0, 32'h0000_1238, 32'h0, 0, got, rdata, cycles);
        check("rd_after_wm_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_after_wm_hits", 32'(hit_count), 32'd4);

        // Unaligned read miss: memory address must be line-aligned.
        do_req(1'b0, 32'h0000_ABCC, 32'h0, 1, got, rdata, cycles);
        check("unal_mem_addr", last_mem_addr, 32'h0000_ABC0);
        check("unal_rdata", rdata, 32'h8888_7777);
        check("unal_miss_count", 32'(miss_count), 32'd3);

        // Reset lands in ALLOCATE together with the memory ack.
        rf0 = refill_cnt;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_5670;
        cyc();
        cyc();
        check("alloc_mem_req", 32'(mem_req), 32'd1);
        rst     = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("rst_ack_refill", 32'(da_refill), 32'd0);
        cyc();
        check("rst_alloc_mem_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        rst     = 1'b0;
        cpu_req = 1'b0;
        cyc();
        check("rst_alloc_refills", 32'(refill_cnt - rf0), 32'd0);
        check("rst_alloc_miss_count", 32'(miss_count), 32'd0);
        check("rst_alloc_hit_count", 32'(hit_count), 32'd0);

        rd0 = mem_rd_cnt;
        do_req(1'b0, 32'h0000_5670, 32'h0, 1, got, rdata, cycles);
        check("post_rst_mem_reads", 32'(mem_rd_cnt - rd0), 32'd1);
        check("post_rst_rdata", rdata, 32'h2222_1111);
        check("post_rst_miss_count", 32'(miss_count), 32'd1);

        // Lines filled before reset are invalid now.
        do_req(1'b0, 32'h0000_1238, 32'h0, 0, got, rdata, cycles);
        check("post_rst_old_rdata", rdata, 32'h6666_5555);
        check("post_rst_old_miss", 32'(miss_count), 32'd2);
        check("post_rst_hit_count", 32'(hit_count), 32'd0);

        check("refill_update_overlap", 32'(both_cnt), 32'd0);
        check("mem_stability", 32'(stab_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
